// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-wide data memory bus between the load/store unit and memory
interface load_store_unit_if;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: zero-extending loads, read-modify-write sub-word stores
module load_store_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [4:0]          op,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         rdata,
  load_store_unit_if.master   mem
);

  localparam logic [4:0] OP_LBU = 5'd12;
  localparam logic [4:0] OP_LHU = 5'd13;
  localparam logic [4:0] OP_LW  = 5'd14;
  localparam logic [4:0] OP_SB  = 5'd15;
  localparam logic [4:0] OP_SH  = 5'd16;
  localparam logic [4:0] OP_SW  = 5'd17;

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  op_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] wr_word;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] wait_cnt;

  logic        illegal, misaligned, bad, load_q, at_limit;
  logic [4:0]  sh;
  logic [31:0] rd_sh, ld_data, ins, mask, merged;

  assign illegal    = (op < OP_LBU) || (op > OP_SW);
  assign misaligned = ((op == OP_LHU || op == OP_SH) && addr[0]) ||
                      ((op == OP_LW  || op == OP_SW) && addr[1:0] != 2'b00);
  assign bad        = illegal || misaligned;
  assign load_q     = (op_q == OP_LBU) || (op_q == OP_LHU) || (op_q == OP_LW);
  assign at_limit   = (wait_cnt == 16'(MAX_WAIT - 1));

  // Accepted halfword accesses are aligned, so one shifter serves both lane sizes.
  assign sh      = {addr_q[1:0], 3'b000};
  assign rd_sh   = mem.mem_rdata >> sh;
  assign ld_data = (op_q == OP_LBU) ? {24'b0, rd_sh[7:0]} :
                   (op_q == OP_LHU) ? {16'b0, rd_sh[15:0]} : mem.mem_rdata;
  assign ins     = (op_q == OP_SB) ? {24'b0, wdata_q[7:0]} : {16'b0, wdata_q};
  assign mask    = (op_q == OP_SB) ? 32'h0000_00FF : 32'h0000_FFFF;
  assign merged  = (wr_word & ~(mask << sh)) | (ins << sh);

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = bad ? DONE : ((op == OP_SW) ? WR : RD);
      RD: begin
        if (mem.mem_ready) state_d = load_q ? DONE : MERGE;
        else if (at_limit) state_d = DONE;
      end
      MERGE: state_d = WR;
      WR:    if (mem.mem_ready || at_limit) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mem.mem_re = 1'b0;
    mem.mem_we = 1'b0;
    case (state_q)
      RD:      begin busy = 1'b1; mem.mem_re = 1'b1; end
      MERGE:   busy = 1'b1;
      WR:      begin busy = 1'b1; mem.mem_we = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_word  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q     <= op;
          addr_q   <= addr;
          wdata_q  <= wdata[15:0];
          err_q    <= bad;
          wait_cnt <= '0;
          if (op == OP_SW && !bad) wr_word <= wdata;
        end
        RD: begin
          if (mem.mem_ready) begin
            if (load_q) rdata_q <= ld_data;
            else        wr_word <= mem.mem_rdata;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            if (at_limit) err_q <= 1'b1;
          end
        end
        MERGE: begin
          wr_word  <= merged;
          wait_cnt <= '0;
        end
        WR: if (!mem.mem_ready) begin
          wait_cnt <= wait_cnt + 16'd1;
          if (at_limit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err           = err_q;
  assign rdata         = rdata_q;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_wdata = wr_word;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed bench for load_store_unit with MAX_WAIT=4
module tb_load_store_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op    = 5'd0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err;
  logic [31:0] rdata;
  int          checks = 0;
  int          errors = 0;

  load_store_unit_if mem ();

  load_store_unit #(.MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .mem(mem)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [4:0] o, input logic [31:0] a, input logic [31:0] w);
    op = o; addr = a; wdata = w; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h0;
    reset = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (mem.mem_re !== 1'b0 || mem.mem_we !== 1'b0) begin errors++; $display("FAIL reset_req: got re=%0b we=%0b want 0 0", mem.mem_re, mem.mem_we); end
    checks++; if (mem.mem_addr !== 32'h0 || mem.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0 0", mem.mem_addr, mem.mem_wdata); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_lw();
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h1122_3344;
    pulse(5'd14, 32'h10, 32'h0);
    checks++; if (mem.mem_re !== 1'b1 || mem.mem_addr !== 32'h10) begin errors++; $display("FAIL lw_rd: got re=%0b addr=%h want 1 00000010", mem.mem_re, mem.mem_addr); end
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lw_busy: got done=%0b busy=%0b want 0 1", done, busy); end
    step();
    checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lw_done: got done=%0b err=%0b busy=%0b want 1 0 0", done, err, busy); end
    checks++; if (rdata !== 32'h1122_3344) begin errors++; $display("FAIL lw_rdata: got %h want 11223344", rdata); end
    checks++; if (mem.mem_re !== 1'b0) begin errors++; $display("FAIL lw_re_drop: got %0b want 0", mem.mem_re); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lw_done_pulse: got %0b want 0", done); end
  endtask

  task automatic test_subword_loads();
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'hA1B2_C3D4;
    pulse(5'd12, 32'h13, 32'h0); step();
    checks++; if (done !== 1'b1 || rdata !== 32'h0000_00A1) begin errors++; $display("FAIL lbu13: got done=%0b rdata=%h want 1 000000a1", done, rdata); end
    step();
    pulse(5'd13, 32'h12, 32'h0); step();
    checks++; if (done !== 1'b1 || rdata !== 32'h0000_A1B2) begin errors++; $display("FAIL lhu12: got done=%0b rdata=%h want 1 0000a1b2", done, rdata); end
    step();
    pulse(5'd12, 32'h10, 32'h0); step();
    checks++; if (done !== 1'b1 || rdata !== 32'h0000_00D4) begin errors++; $display("FAIL lbu10: got done=%0b rdata=%h want 1 000000d4", done, rdata); end
    step();
  endtask

  task automatic test_stores();
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h1122_3344;
    pulse(5'd15, 32'h21, 32'hFFFF_FF5A);
    checks++; if (mem.mem_re !== 1'b1 || mem.mem_addr !== 32'h20) begin errors++; $display("FAIL sb_rd: got re=%0b addr=%h want 1 00000020", mem.mem_re, mem.mem_addr); end
    step();
    checks++; if (mem.mem_re !== 1'b0 || mem.mem_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sb_merge: got re=%0b we=%0b busy=%0b want 0 0 1", mem.mem_re, mem.mem_we, busy); end
    step();
    checks++; if (mem.mem_we !== 1'b1 || mem.mem_wdata !== 32'h1122_5A44 || mem.mem_addr !== 32'h20) begin errors++; $display("FAIL sb_wr: got we=%0b wdata=%h addr=%h want 1 11225a44 00000020", mem.mem_we, mem.mem_wdata, mem.mem_addr); end
    step();
    checks++; if (done !== 1'b1 || err !== 1'b0 || mem.mem_we !== 1'b0) begin errors++; $display("FAIL sb_done: got done=%0b err=%0b we=%0b want 1 0 0", done, err, mem.mem_we); end
    step();
    pulse(5'd16, 32'h22, 32'hABCD_1234); step(); step();
    checks++; if (mem.mem_we !== 1'b1 || mem.mem_wdata !== 32'h1234_3344) begin errors++; $display("FAIL sh_wr: got we=%0b wdata=%h want 1 12343344", mem.mem_we, mem.mem_wdata); end
    step();
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL sh_done: got done=%0b err=%0b want 1 0", done, err); end
    step();
    pulse(5'd17, 32'h24, 32'hDEAD_BEEF);
    checks++; if (mem.mem_we !== 1'b1 || mem.mem_wdata !== 32'hDEAD_BEEF || mem.mem_addr !== 32'h24) begin errors++; $display("FAIL sw_wr: got we=%0b wdata=%h addr=%h want 1 deadbeef 00000024", mem.mem_we, mem.mem_wdata, mem.mem_addr); end
    step();
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL sw_done: got done=%0b err=%0b want 1 0", done, err); end
    step();
  endtask

  task automatic test_errors();
    logic [4:0]  ops [3] = '{5'd16, 5'd14, 5'd2};
    logic [31:0] adrs[3] = '{32'h31, 32'h42, 32'h40};
    mem.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse(ops[i], adrs[i], 32'h0);
      checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL err_case%0d: got done=%0b err=%0b want 1 1", i, done, err); end
      checks++; if (mem.mem_re !== 1'b0 || mem.mem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_noacc%0d: got re=%0b we=%0b busy=%0b want 0 0 0", i, mem.mem_re, mem.mem_we, busy); end
      step();
      checks++; if (done !== 1'b0 || mem.mem_re !== 1'b0) begin errors++; $display("FAIL err_after%0d: got done=%0b re=%0b want 0 0", i, done, mem.mem_re); end
    end
  endtask

  task automatic test_timeout();
    int re_cycles;
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h0123_4567;
    pulse(5'd14, 32'h50, 32'h0); step(); step();
    mem.mem_ready = 1'b0; mem.mem_rdata = 32'hCAFE_F00D;
    pulse(5'd14, 32'h54, 32'h0);
    re_cycles = 0;
    for (int i = 0; i < 6 && done !== 1'b1; i++) begin
      if (mem.mem_re === 1'b1) re_cycles++;
      step();
    end
    checks++; if (re_cycles != 4) begin errors++; $display("FAIL to_re_cycles: got %0d want 4", re_cycles); end
    checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL to_done: got done=%0b err=%0b want 1 1", done, err); end
    checks++; if (rdata !== 32'h0123_4567) begin errors++; $display("FAIL to_rdata: got %h want 01234567", rdata); end
    step();
    pulse(5'd14, 32'h58, 32'h0); step(); step();
    mem.mem_ready = 1'b1;
    checks++; if (mem.mem_re !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL wait2_rd: got re=%0b done=%0b want 1 0", mem.mem_re, done); end
    step();
    checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wait2_done: got done=%0b err=%0b rdata=%h want 1 0 cafef00d", done, err, rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    mem.mem_ready = 1'b0;
    pulse(5'd17, 32'h60, 32'h5555_AAAA); step();
    checks++; if (mem.mem_we !== 1'b1) begin errors++; $display("FAIL mid_we: got %0b want 1", mem.mem_we); end
    reset = 1'b0; step(); reset = 1'b1;
    checks++; if (mem.mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset: got we=%0b busy=%0b done=%0b want 0 0 0", mem.mem_we, busy, done); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_nodone: got done=%0b busy=%0b want 0 0", done, busy); end
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h7788_99AA;
    pulse(5'd14, 32'h70, 32'h0); step();
    checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'h7788_99AA) begin errors++; $display("FAIL mid_relw: got done=%0b err=%0b rdata=%h want 1 0 778899aa", done, err, rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    mem.mem_ready = 1'b1; mem.mem_rdata = 32'h0BAD_F00D;
    op = 5'd14; addr = 32'h80; start = 1'b1;
    step(); step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %0b want 1", done); end
    step();
    checks++; if (busy !== 1'b0 || mem.mem_re !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%0b re=%0b want 0 0", busy, mem.mem_re); end
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || mem.mem_re !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%0b re=%0b want 1 1", busy, mem.mem_re); end
    step();
    checks++; if (done !== 1'b1 || rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_done2: got done=%0b rdata=%h want 1 0badf00d", done, rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_subword_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
